i_test_pattern_gen: RTL and testbench



---
 rtl/i_video_pkg.sv | 29 ++
 rtl/i_pattern_pixel.sv | 35 +++
 rtl/i_test_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_i_test_pattern_gen.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_video_pkg.sv
// Shared video definitions: pattern codes, default 640x480 raster timing and the
// generator FSM state type.
package i_video_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_BLANK  = 45;

  localparam logic [1:0] PAT_RAMP  = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FILL  = 2'd3;

  // Eight equal bars spread over the full 8-bit range: 0x00, 0x24, ... 0xFC.
  localparam logic [7:0] BAR_STEP = 8'd36;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  function automatic logic [7:0] bar_value(input logic [2:0] bar);
    return {5'd0, bar} * BAR_STEP;
  endfunction

endpackage

// File: rtl/i_pattern_pixel.sv
// Combinational pixel value for the selected greyscale test pattern at (x, y).
// Outside the active region the result is don't-care; the caller masks it.
module i_pattern_pixel
  import i_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  pat,
  input  logic [7:0]  frame_cnt,
  output logic [7:0]  value
);

  localparam logic [15:0] BAR_WIDTH = 16'(H_ACTIVE / 8);

  logic [15:0] bar_full;
  logic        unused_bits;

  // Constant divisor; only the low three bits matter inside the active region.
  assign bar_full    = x / BAR_WIDTH;
  assign unused_bits = ^{bar_full[15:3], y[15:4], y[2:0]};

  always_comb begin
    value = 8'h00;
    case (pat)
      PAT_RAMP:  value = x[7:0];
      PAT_BARS:  value = bar_value(bar_full[2:0]);
      PAT_CHECK: value = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      PAT_FILL:  value = frame_cnt;
      default:   value = 8'h00;
    endcase
  end

endmodule

// File: rtl/i_test_pattern_gen.sv
// Synthetic raster source: h/v counters, sync/valid generation and registered
// test-pattern pixels, all one cycle behind the counters.
module i_test_pattern_gen
  import i_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_BLANK  = DEF_V_BLANK
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       vsync,
  output logic       hsync,
  output logic       vde,
  output logic [7:0] o_data,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  // One extra bit so a sync pulse ending exactly at H_TOTAL cannot overflow.
  localparam logic [HW:0]   H_ACT_END = (HW + 1)'(H_ACTIVE);
  localparam logic [HW:0]   HS_START  = (HW + 1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   HS_END    = (HW + 1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_END = (VW + 1)'(V_ACTIVE);

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    pat_q, pat_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic       vsync_q, vsync_d;
  logic       hsync_q, hsync_d;
  logic       vde_q, vde_d;
  logic [7:0] data_q, data_d;
  logic       frame_start_q, frame_start_d;

  logic        run;
  logic        frame_last;
  logic [HW:0] h_ext;
  logic [VW:0] v_ext;
  logic [15:0] x16;
  logic [15:0] y16;
  logic [7:0]  pix;

  assign run        = (state_q == StRun);
  assign frame_last = (h_q == H_LAST) && (v_q == V_LAST);
  assign h_ext      = {1'b0, h_q};
  assign v_ext      = {1'b0, v_q};
  assign x16        = 16'(h_q);
  assign y16        = 16'(v_q);

  i_pattern_pixel #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pixel (
    .x         (x16),
    .y         (y16),
    .pat       (pat_q),
    .frame_cnt (frame_cnt_q),
    .value     (pix)
  );

  // State register.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a frame, once started, always runs to its last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (frame_last && !enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counters, pattern latch and frame counter.
  always_comb begin
    h_d         = '0;
    v_d         = '0;
    pat_d       = pat_q;
    frame_cnt_d = frame_cnt_q;
    if (run) begin
      if (h_q == H_LAST) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
        v_d = v_q;
      end
      if (frame_last) frame_cnt_d = frame_cnt_q + 8'd1;
    end
    if (enable && (!run || frame_last)) pat_d = pattern_sel;
  end

  // Output decode from the current counters, registered below.
  always_comb begin
    vde_d         = run && (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    vsync_d       = run && (v_ext < V_ACT_END);
    hsync_d       = !(run && (h_ext >= HS_START) && (h_ext < HS_END));
    frame_start_d = run && (h_q == '0) && (v_q == '0);
    data_d        = vde_d ? pix : 8'h00;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      pat_q         <= PAT_RAMP;
      frame_cnt_q   <= 8'h00;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b1;
      vde_q         <= 1'b0;
      data_q        <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      pat_q         <= pat_d;
      frame_cnt_q   <= frame_cnt_d;
      vsync_q       <= vsync_d;
      hsync_q       <= hsync_d;
      vde_q         <= vde_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vsync       = vsync_q;
  assign hsync       = hsync_q;
  assign vde         = vde_q;
  assign o_data      = data_q;
  assign frame_start = frame_start_q;
  assign busy        = run;

endmodule

// File: tb/tb_i_test_pattern_gen.sv
// Directed bench for i_test_pattern_gen with a 14x10 raster (plus a 14x18 copy
// for the second checker row).
module tb_i_test_pattern_gen;

  logic       pclk;
  logic       reset_n;
  logic       enable;
  logic       en16;
  logic [1:0] pattern_sel;

  logic       vsync, hsync, vde, frame_start, busy;
  logic [7:0] o_data;
  logic       vsync16, hsync16, vde16, frame_start16, busy16;
  logic [7:0] o_data16;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] got;
  logic [11:0] exp;

  logic [7:0] bars_tbl [8] = '{8'h00, 8'h24, 8'h48, 8'h6C, 8'h90, 8'hB4, 8'hD8, 8'hFC};

  localparam logic [11:0] IDLE_VEC = 12'h400;  // vsync 0, hsync 1, vde 0, fs 0, data 0

  i_test_pattern_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (8),
    .V_BLANK  (2)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .vsync       (vsync),
    .hsync       (hsync),
    .vde         (vde),
    .o_data      (o_data),
    .frame_start (frame_start),
    .busy        (busy)
  );

  i_test_pattern_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (16),
    .V_BLANK  (2)
  ) dut16 (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .enable      (en16),
    .pattern_sel (pattern_sel),
    .vsync       (vsync16),
    .hsync       (hsync16),
    .vde         (vde16),
    .o_data      (o_data16),
    .frame_start (frame_start16),
    .busy        (busy16)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(negedge pclk);
  endtask

  // Expected {vsync, hsync, vde, frame_start, data} for output cycle j of a frame.
  function automatic logic [11:0] exp_out(input int j, input int pat, input logic [7:0] fill,
                                          input int va);
    int h;
    int v;
    logic act;
    logic [7:0] d;
    h   = j % 14;
    v   = j / 14;
    act = (h < 8) && (v < va);
    case (pat)
      0:       d = 8'(h);
      1:       d = bars_tbl[h % 8];
      2:       d = ((((h / 8) ^ (v / 8)) % 2) == 1) ? 8'hFF : 8'h00;
      default: d = fill;
    endcase
    if (!act) d = 8'h00;
    return {v < va, !(h >= 10 && h < 12), act, j == 0, d};
  endfunction

  task automatic test_reset();
    reset_n     = 1'b0;
    enable      = 1'b0;
    en16        = 1'b0;
    pattern_sel = 2'd0;
    #12;
    got = {vsync, hsync, vde, frame_start, o_data};
    n_checks++;
    if (got !== IDLE_VEC) begin
      n_errors++;
      $display("FAIL reset_outputs got=%h exp=%h", got, IDLE_VEC);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    got = {vsync, hsync, vde, frame_start, o_data};
    n_checks++;
    if (got !== IDLE_VEC || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_hold got=%h busy=%b exp=%h busy=0", got, busy, IDLE_VEC);
    end
  endtask

  task automatic test_ramp();
    pattern_sel = 2'd0;
    enable      = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b0 || busy !== 1'b1 || vde !== 1'b0) begin
      n_errors++;
      $display("FAIL start_latency fs=%b busy=%b vde=%b exp fs=0 busy=1 vde=0",
               frame_start, busy, vde);
    end
    tick();
    for (int j = 0; j < 140; j++) begin
      got = {vsync, hsync, vde, frame_start, o_data};
      exp = exp_out(j, 0, 8'h00, 8);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL ramp j=%0d got=%h exp=%h", j, got, exp);
      end
      tick();
    end
    n_checks++;
    if (frame_start !== 1'b1 || vde !== 1'b1) begin
      n_errors++;
      $display("FAIL frame_period fs=%b vde=%b exp fs=1 vde=1", frame_start, vde);
    end
  endtask

  // Selection changed at the start of a running frame only applies to the next frame.
  task automatic test_bars();
    pattern_sel = 2'd1;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 140; j++) begin
        got = {vsync, hsync, vde, frame_start, o_data};
        exp = exp_out(j, f, 8'h00, 8);
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL bars f=%0d j=%0d got=%h exp=%h", f, j, got, exp);
        end
        tick();
      end
    end
  endtask

  task automatic test_checker();
    pattern_sel = 2'd2;
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 140; j++) begin
        got = {vsync, hsync, vde, frame_start, o_data};
        exp = exp_out(j, f + 1, 8'h00, 8);
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL checker f=%0d j=%0d got=%h exp=%h", f, j, got, exp);
        end
        tick();
      end
    end
    en16 = 1'b1;
    tick();
    tick();
    for (int j = 0; j < 252; j++) begin
      got = {vsync16, hsync16, vde16, frame_start16, o_data16};
      exp = exp_out(j, 2, 8'h00, 16);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL checker16 j=%0d got=%h exp=%h", j, got, exp);
      end
      en16 = 1'b0;
      tick();
    end
    n_checks++;
    if (busy16 !== 1'b0 || vde16 !== 1'b0) begin
      n_errors++;
      $display("FAIL checker16_stop busy=%b vde=%b exp busy=0 vde=0", busy16, vde16);
    end
  endtask

  task automatic test_fill();
    reset_n = 1'b0;
    tick();
    reset_n     = 1'b1;
    pattern_sel = 2'd3;
    enable      = 1'b1;
    tick();
    tick();
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 140; j++) begin
        got = {vsync, hsync, vde, frame_start, o_data};
        exp = (f < 3) ? exp_out(j, 3, 8'(f), 8) : exp_out(j, 1, 8'h00, 8);
        n_checks++;
        if (got !== exp) begin
          n_errors++;
          $display("FAIL fill f=%0d j=%0d got=%h exp=%h", f, j, got, exp);
        end
        if (f == 2 && j == 30) pattern_sel = 2'd1;
        tick();
      end
    end
  endtask

  task automatic test_enable_drop();
    for (int j = 0; j < 140; j++) begin
      got = {vsync, hsync, vde, frame_start, o_data};
      exp = exp_out(j, 1, 8'h00, 8);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL drop_frame j=%0d got=%h exp=%h", j, got, exp);
      end
      if (j == 30) enable = 1'b0;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      got = {vsync, hsync, vde, frame_start, o_data};
      n_checks++;
      if (got !== IDLE_VEC || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL drop_idle k=%0d got=%h busy=%b exp=%h busy=0", k, got, busy, IDLE_VEC);
      end
      tick();
      tick();
    end
    pattern_sel = 2'd0;
    enable      = 1'b1;
    tick();
    n_checks++;
    if (frame_start !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reenable_latency fs=%b busy=%b exp fs=0 busy=1", frame_start, busy);
    end
    tick();
    for (int j = 0; j < 20; j++) begin
      got = {vsync, hsync, vde, frame_start, o_data};
      exp = exp_out(j, 0, 8'h00, 8);
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reenable j=%0d got=%h exp=%h", j, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    n_checks++;
    if (vde !== 1'b1 || o_data !== 8'h06) begin
      n_errors++;
      $display("FAIL pre_reset vde=%b data=%h exp vde=1 data=06", vde, o_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    got = {vsync, hsync, vde, frame_start, o_data};
    n_checks++;
    if (got !== IDLE_VEC || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset got=%h busy=%b exp=%h busy=0", got, busy, IDLE_VEC);
    end
    enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || vde !== 1'b0) begin
      n_errors++;
      $display("FAIL post_reset_idle busy=%b vde=%b exp busy=0 vde=0", busy, vde);
    end
    pattern_sel = 2'd3;
    enable      = 1'b1;
    tick();
    tick();
    got = {vsync, hsync, vde, frame_start, o_data};
    n_checks++;
    if (got !== 12'hF00) begin
      n_errors++;
      $display("FAIL post_reset_fill got=%h exp=f00", got);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_bars();
    test_checker();
    test_fill();
    test_enable_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
